// File: rtl/mem64_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem64_arbiter_if
//  Purpose  : Bundle of requester handshakes, response and memory pins shared
//             between the two bus masters, the arbiter and the data memory.
//  Revision : 1.0  initial release
// ============================================================================
interface mem64_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  // Requester side
  logic              req0_valid;
  logic              req0_wr;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              req1_valid;
  logic              req1_wr;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  // Response side
  logic              rsp0_valid;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp_rdata;
  // Memory side
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;
  // Status
  logic              busy;

  // Arbiter view
  modport slave (
    input  req0_valid, req0_wr, req0_addr, req0_wdata,
    input  req1_valid, req1_wr, req1_addr, req1_wdata,
    input  mem_rdata,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata,
    output mem_addr, mem_wdata, mem_wr, busy
  );

  // Requesters plus memory view
  modport master (
    output req0_valid, req0_wr, req0_addr, req0_wdata,
    output req1_valid, req1_wr, req1_addr, req1_wdata,
    output mem_rdata,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata,
    input  mem_addr, mem_wdata, mem_wr, busy
  );
endinterface
`default_nettype wire

// File: rtl/mem64_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem64_arbiter
//  Purpose  : Two-port arbiter and single-transaction sequencer in front of
//             the shared 64-bit data memory. Port 0 has priority; port 1 is
//             forced through after MAX_WAIT consecutive losses.
//  Revision : 1.0  initial release
// ============================================================================
module mem64_arbiter #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  mem64_arbiter_if.slave  bus_io
);

  localparam int LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STARVE_W = $clog2(MAX_WAIT + 1);
  localparam logic [LAT_W-1:0]    LAT_LOAD   = LAT_W'(MEM_LAT - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_WAITLAT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              state_q,  state_d;
  logic                owner_q,  owner_d;
  logic                wr_q,     wr_d;
  logic [ADDR_W-1:0]   addr_q,   addr_d;
  logic [DATA_W-1:0]   wdata_q,  wdata_d;
  logic [LAT_W-1:0]    lat_q,    lat_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [DATA_W-1:0]   rdata_q,  rdata_d;

  logic w_pick1;
  logic w_ready0, w_ready1;
  logic w_rsp0,   w_rsp1;

  // Port 1 wins when alone, or when it has lost MAX_WAIT arbitrations in a row
  assign w_pick1 = bus_io.req1_valid &&
                   (!bus_io.req0_valid || (starve_q == STARVE_MAX));

  // State and transaction latches; reset drops any in-flight access
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      lat_q    <= '0;
      starve_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
      rdata_q  <= rdata_d;
    end
  end

  // Next-state, arbitration and per-state handshake outputs
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    lat_d    = lat_q;
    starve_d = starve_q;
    rdata_d  = rdata_q;
    w_ready0 = 1'b0;
    w_ready1 = 1'b0;
    w_rsp0   = 1'b0;
    w_rsp1   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!bus_io.req1_valid) begin
          starve_d = '0;
        end
        if (bus_io.req0_valid || bus_io.req1_valid) begin
          state_d = S_ACCESS;
          owner_d = w_pick1;
          wr_d    = w_pick1 ? bus_io.req1_wr    : bus_io.req0_wr;
          addr_d  = w_pick1 ? bus_io.req1_addr  : bus_io.req0_addr;
          wdata_d = w_pick1 ? bus_io.req1_wdata : bus_io.req0_wdata;
          if (w_pick1) begin
            w_ready1 = 1'b1;
            starve_d = '0;
          end else begin
            w_ready0 = 1'b1;
            if (bus_io.req1_valid && (starve_q != STARVE_MAX)) begin
              starve_d = starve_q + 1'b1;
            end
          end
        end
      end
      S_ACCESS: begin
        if (wr_q) begin
          state_d = S_DONE;
        end else begin
          lat_d   = LAT_LOAD;
          state_d = S_WAITLAT;
        end
      end
      S_WAITLAT: begin
        if (lat_q == '0) begin
          rdata_d = bus_io.mem_rdata;
          state_d = S_DONE;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      S_DONE: begin
        w_rsp0  = !owner_q;
        w_rsp1  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Ready is masked by reset so nothing is accepted while reset is held
  assign bus_io.req0_ready = w_ready0 & ~rst_i;
  assign bus_io.req1_ready = w_ready1 & ~rst_i;
  assign bus_io.rsp0_valid = w_rsp0;
  assign bus_io.rsp1_valid = w_rsp1;
  assign bus_io.rsp_rdata  = rdata_q;
  assign bus_io.mem_addr   = addr_q;
  assign bus_io.mem_wdata  = wdata_q;
  assign bus_io.mem_wr     = (state_q == S_ACCESS) && wr_q;
  assign bus_io.busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem64_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem64_arbiter
//  Purpose  : Self-checking bench for mem64_arbiter: transaction-level model
//             compared every cycle, directed literal checks, random traffic,
//             and a second instance with a longer memory latency.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem64_arbiter;

  localparam int LAT_A  = 1;
  localparam int WAIT_A = 4;
  localparam int LAT_B  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem64_arbiter_if #(.ADDR_W(64), .DATA_W(64)) ifa ();
  mem64_arbiter_if #(.ADDR_W(64), .DATA_W(64)) ifb ();

  mem64_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(LAT_A), .MAX_WAIT(WAIT_A))
    u_dut_a (.clk_i(clk), .rst_i(rst), .bus_io(ifa));
  mem64_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(LAT_B), .MAX_WAIT(2))
    u_dut_b (.clk_i(clk), .rst_i(rst), .bus_io(ifb));

  function automatic logic [63:0] init_val(input int i);
    if (i == 8) return 64'hDEADBEEF_CAFEF00D;
    return {32'(i) * 32'h9E37_79B9, 32'h0BAD_0000 | 32'(i)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- memories (environment) ----------------
  logic [63:0] mem_a [32];
  logic [63:0] mem_b [32];
  logic [63:0] rd_a;
  logic [63:0] pb1, pb2, pb3;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem_a[i] <= init_val(i);
    end else if (ifa.mem_wr) begin
      mem_a[ifa.mem_addr[7:3]] <= ifa.mem_wdata;
    end
    rd_a <= mem_a[ifa.mem_addr[7:3]];
  end

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem_b[i] <= init_val(i);
    end else if (ifb.mem_wr) begin
      mem_b[ifb.mem_addr[7:3]] <= ifb.mem_wdata;
    end
    pb1 <= mem_b[ifb.mem_addr[7:3]];
    pb2 <= pb1;
    pb3 <= pb2;
  end

  assign ifa.mem_rdata = rd_a;
  assign ifb.mem_rdata = pb3;

  // ---------------- transaction-level model of instance A ----------------
  logic [63:0] m_mem [32];
  bit          m_active;
  int          m_t;
  bit          m_owner, m_wr;
  logic [63:0] m_addr, m_wdata, m_rdata;
  int          m_starve;

  always @(negedge clk) begin
    bit r0, r1, win, e_r0, e_r1, e_rsp0, e_rsp1, e_mwr;
    int dur;
    if (preload) begin
      for (int i = 0; i < 32; i++) m_mem[i] = init_val(i);
    end
    if (rst) begin
      m_active = 0; m_t = 0; m_owner = 0; m_wr = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0; m_starve = 0;
      chk("rst_busy",   {63'd0, ifa.busy},       64'd0);
      chk("rst_mem_wr", {63'd0, ifa.mem_wr},     64'd0);
      chk("rst_ready",  {62'd0, ifa.req1_ready, ifa.req0_ready}, 64'd0);
      chk("rst_rsp",    {62'd0, ifa.rsp1_valid, ifa.rsp0_valid}, 64'd0);
      chk("rst_rdata",  ifa.rsp_rdata, 64'd0);
      chk("rst_addr",   ifa.mem_addr,  64'd0);
      chk("rst_wdata",  ifa.mem_wdata, 64'd0);
    end else begin
      r0 = ifa.req0_valid; r1 = ifa.req1_valid;
      win = r1 && (!r0 || m_starve == WAIT_A);
      e_r0 = 0; e_r1 = 0; e_rsp0 = 0; e_rsp1 = 0; e_mwr = 0;
      dur = m_wr ? 2 : 2 + LAT_A;
      if (!m_active) begin
        if (r0 || r1) begin e_r0 = !win; e_r1 = win; end
      end else begin
        e_mwr = m_wr && (m_t == 1);
        if (m_t == dur) begin
          e_rsp0 = !m_owner; e_rsp1 = m_owner;
          if (!m_wr) m_rdata = m_mem[m_addr[7:3]];
        end
      end
      chk("ready0", {63'd0, ifa.req0_ready}, {63'd0, e_r0});
      chk("ready1", {63'd0, ifa.req1_ready}, {63'd0, e_r1});
      chk("rsp0",   {63'd0, ifa.rsp0_valid}, {63'd0, e_rsp0});
      chk("rsp1",   {63'd0, ifa.rsp1_valid}, {63'd0, e_rsp1});
      chk("mem_wr", {63'd0, ifa.mem_wr},     {63'd0, e_mwr});
      chk("busy",   {63'd0, ifa.busy},       {63'd0, m_active});
      chk("mem_addr",  ifa.mem_addr,  m_addr);
      chk("mem_wdata", ifa.mem_wdata, m_wdata);
      chk("rsp_rdata", ifa.rsp_rdata, m_rdata);
      // advance to the next cycle
      if (!m_active) begin
        if (!r1 || ((r0 || r1) && win)) m_starve = 0;
        else if (m_starve < WAIT_A) m_starve++;
        if (r0 || r1) begin
          m_active = 1; m_t = 1; m_owner = win;
          m_wr    = win ? ifa.req1_wr    : ifa.req0_wr;
          m_addr  = win ? ifa.req1_addr  : ifa.req0_addr;
          m_wdata = win ? ifa.req1_wdata : ifa.req0_wdata;
        end
      end else begin
        if (m_wr && m_t == 1) m_mem[m_addr[7:3]] = m_wdata;
        if (m_t == dur) m_active = 0;
        else m_t++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic to_drv();
    @(posedge clk); #1;
  endtask

  task automatic set_a(input int port, input bit v, input bit wr,
                       input logic [63:0] addr, input logic [63:0] wd);
    if (port == 0) begin
      ifa.req0_valid = v; ifa.req0_wr = wr; ifa.req0_addr = addr; ifa.req0_wdata = wd;
    end else begin
      ifa.req1_valid = v; ifa.req1_wr = wr; ifa.req1_addr = addr; ifa.req1_wdata = wd;
    end
  endtask

  // Wait (bounded) until response on port, then check data
  task automatic wait_rsp(input int port, input logic [63:0] exp, input string nm);
    bit got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if ((port == 0) ? ifa.rsp0_valid : ifa.rsp1_valid) begin
        got = 1;
        chk(nm, ifa.rsp_rdata, exp);
      end
    end
    if (!got) chk({nm, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int win_seq [10];
    int n_arb;
    bit a0, a1;
    set_a(0, 0, 0, 0, 0); set_a(1, 0, 0, 0, 0);
    ifb.req0_valid = 0; ifb.req0_wr = 0; ifb.req0_addr = 0; ifb.req0_wdata = 0;
    ifb.req1_valid = 0; ifb.req1_wr = 0; ifb.req1_addr = 0; ifb.req1_wdata = 0;
    repeat (3) to_drv();
    rst = 0; preload = 0;
    to_drv();

    // Single read of 0x40 on port 0
    set_a(0, 1, 0, 64'h40, 0);
    @(negedge clk); chk("rd_ready0_T", {63'd0, ifa.req0_ready}, 64'd1);
    to_drv(); set_a(0, 0, 0, 0, 0);
    @(negedge clk); chk("rd_addr_T1", ifa.mem_addr, 64'h40);
                    chk("rd_rsp0_T1", {63'd0, ifa.rsp0_valid}, 64'd0);
    @(negedge clk); chk("rd_rsp0_T2", {63'd0, ifa.rsp0_valid}, 64'd0);
    @(negedge clk); chk("rd_rsp0_T3", {63'd0, ifa.rsp0_valid}, 64'd1);
                    chk("rd_data_T3", ifa.rsp_rdata, 64'hDEADBEEF_CAFEF00D);
                    chk("rd_rsp1_T3", {63'd0, ifa.rsp1_valid}, 64'd0);
    to_drv();

    // Single write of 0x1234 to 0x80 on port 1, then read back on port 0
    set_a(1, 1, 1, 64'h80, 64'h1234);
    @(negedge clk); chk("wr_ready1_T", {63'd0, ifa.req1_ready}, 64'd1);
    to_drv(); set_a(1, 0, 0, 0, 0);
    @(negedge clk); chk("wr_memwr_T1", {63'd0, ifa.mem_wr}, 64'd1);
                    chk("wr_addr_T1", ifa.mem_addr, 64'h80);
                    chk("wr_wdata_T1", ifa.mem_wdata, 64'h1234);
    @(negedge clk); chk("wr_memwr_T2", {63'd0, ifa.mem_wr}, 64'd0);
                    chk("wr_rsp1_T2", {63'd0, ifa.rsp1_valid}, 64'd1);
                    chk("wr_rdata_keep", ifa.rsp_rdata, 64'hDEADBEEF_CAFEF00D);
    to_drv();
    set_a(0, 1, 0, 64'h80, 0);
    to_drv(); set_a(0, 0, 0, 0, 0);
    wait_rsp(0, 64'h1234, "readback_0x80");
    to_drv();

    // Tie: both read in the same IDLE cycle
    set_a(0, 1, 0, 64'h10, 0); set_a(1, 1, 0, 64'h18, 0);
    @(negedge clk); chk("tie_ready0", {63'd0, ifa.req0_ready}, 64'd1);
                    chk("tie_ready1", {63'd0, ifa.req1_ready}, 64'd0);
    to_drv(); set_a(0, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); chk("tie_ready1_busy", {63'd0, ifa.req1_ready}, 64'd0);
    end
    @(negedge clk); chk("tie_ready1_T4", {63'd0, ifa.req1_ready}, 64'd1);
    to_drv(); set_a(1, 0, 0, 0, 0);
    repeat (4) to_drv();

    // Starvation: both ports request continuously
    set_a(0, 1, 1, 64'h20, 64'hAAAA); set_a(1, 1, 1, 64'h28, 64'h5555);
    n_arb = 0;
    for (int k = 0; k < 100 && n_arb < 10; k++) begin
      @(negedge clk);
      if (ifa.req0_ready) begin win_seq[n_arb] = 0; n_arb++; end
      else if (ifa.req1_ready) begin win_seq[n_arb] = 1; n_arb++; end
    end
    to_drv(); set_a(0, 0, 0, 0, 0); set_a(1, 0, 0, 0, 0);
    chk("starve_arb_count", 64'(n_arb), 64'd10);
    for (int k = 0; k < n_arb; k++)
      chk($sformatf("starve_winner_%0d", k), 64'(win_seq[k]),
          (k == 4 || k == 9) ? 64'd1 : 64'd0);
    repeat (4) to_drv();

    // Asynchronous reset during WAITLAT
    set_a(0, 1, 0, 64'h40, 0);
    @(negedge clk); chk("mr_ready0", {63'd0, ifa.req0_ready}, 64'd1);
    to_drv(); set_a(0, 0, 0, 0, 0);
    @(posedge clk); #2 rst = 1;
    #1;
    chk("mr_busy",  {63'd0, ifa.busy}, 64'd0);
    chk("mr_memwr", {63'd0, ifa.mem_wr}, 64'd0);
    chk("mr_rsp",   {62'd0, ifa.rsp1_valid, ifa.rsp0_valid}, 64'd0);
    chk("mr_rdata", ifa.rsp_rdata, 64'd0);
    to_drv(); rst = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("mr_no_rsp", {62'd0, ifa.rsp1_valid, ifa.rsp0_valid}, 64'd0);
      chk("mr_idle",   {63'd0, ifa.busy}, 64'd0);
    end
    to_drv();

    // Random traffic against the model
    a0 = 0; a1 = 0;
    repeat (2500) begin
      @(negedge clk);
      a0 = ifa.req0_ready; a1 = ifa.req1_ready;
      to_drv();
      if (a0 || !ifa.req0_valid)
        set_a(0, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
              {56'd0, 5'($urandom_range(0, 31)), 3'b000}, {$urandom, $urandom});
      else if ($urandom_range(0, 15) == 0) ifa.req0_valid = 0;
      if (a1 || !ifa.req1_valid)
        set_a(1, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
              {56'd0, 5'($urandom_range(0, 31)), 3'b000}, {$urandom, $urandom});
      else if ($urandom_range(0, 15) == 0) ifa.req1_valid = 0;
    end
    set_a(0, 0, 0, 0, 0); set_a(1, 0, 0, 0, 0);
    repeat (8) to_drv();

    // Latency sweep on instance B (MEM_LAT=3)
    ifb.req0_valid = 1; ifb.req0_wr = 0; ifb.req0_addr = 64'h40;
    @(negedge clk); chk("lat3_ready0", {63'd0, ifb.req0_ready}, 64'd1);
                    chk("lat3_busy_T", {63'd0, ifb.busy}, 64'd0);
    to_drv(); ifb.req0_valid = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("lat3_busy_T%0d", k), {63'd0, ifb.busy}, (k <= 5) ? 64'd1 : 64'd0);
      chk($sformatf("lat3_rsp0_T%0d", k), {63'd0, ifb.rsp0_valid}, (k == 5) ? 64'd1 : 64'd0);
      if (k == 4) chk("lat3_rdata_T4", ifb.rsp_rdata, 64'd0);
      if (k == 5) chk("lat3_rdata_T5", ifb.rsp_rdata, 64'hDEADBEEF_CAFEF00D);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem64_arbiter.md
# mem64_arbiter

Two-port arbiter and access sequencer for the shared 64-bit data memory (Memoria64). It lets the CPU datapath (port 0) and a secondary master such as a loader or debug port (port 1) share the memory. Each access is sequenced as a single transaction: accept, present address/write, wait fixed read latency, respond. Port 0 has priority, with a starvation guard for port 1. The block sits between the requesters and the memory's address, data and write-enable pins.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data width
- MEM_LAT, 1, cycles from address presented to mem_rdata valid (≥1)
- MAX_WAIT, 4, consecutive port-0 grants port 1 may lose before it is forced to win (≥1)

- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  request pending
- req0_wr / req1_wr  in  1  1 = write, 0 = read
- req0_addr / req1_addr  in  ADDR_W  byte address
- req0_wdata / req1_wdata  in  DATA_W  write data
- req0_ready / req1_ready  out  1  one-cycle accept pulse
- rsp0_valid / rsp1_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data, registered
- mem_addr  out  ADDR_W  to memory raddress/waddress
- mem_wdata  out  DATA_W  to memory Datain
- mem_wr  out  1  to memory Wr
- mem_rdata  in  DATA_W  from memory Dataout
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, ACCESS, WAITLAT, DONE. Registered latches: owner, wr, addr, wdata, lat_cnt, starve_cnt.
- IDLE with no request pending: stay.
- IDLE with any request pending: select a winner.
  - Latch the winner's fields.
  - Drive reqN_ready=1 combinationally this cycle for the winner only.
  - Go to ACCESS.
- Selection:
  - Only one port requesting: that port wins.
  - Both requesting: port 0 wins, unless starve_cnt == MAX_WAIT, in which case port 1 wins.
- starve_cnt:
  - Increments, saturating at MAX_WAIT, when port 1 is requesting and port 0 is granted.
  - Clears when port 1 is granted, or in any IDLE cycle with req1_valid=0.
- ACCESS (1 cycle):
  - mem_addr=addr; mem_wr=wr.
  - If wr: go to DONE.
  - Otherwise: lat_cnt←MEM_LAT-1 and go to WAITLAT.
- WAITLAT:
  - mem_addr holds addr; mem_wr=0.
  - If lat_cnt==0: rsp_rdata←mem_rdata and go to DONE.
  - Otherwise: decrement lat_cnt.
- DONE (1 cycle): rspN_valid=1 for the owner only, then go to IDLE. No acceptance occurs in DONE.
- rsp_rdata changes only on read capture. Writes leave it unchanged.
- mem_wdata = latched wdata at all times. mem_addr = latched addr at all times. mem_wr is high only in ACCESS with wr=1.
- Requester rules:
  - Requester holds valid/wr/addr/wdata stable until ready.
  - A requester may drop valid before ready; no transaction results.
  - Fields sampled only in the accept cycle.
- Unused addresses or data are passed through unchecked. No error response.

## Timing
- Reset (asynchronous, immediate):
  - State → IDLE.
  - All outputs 0; rsp_rdata=0.
  - All latches and counters 0.
  - An in-flight transaction is dropped with no response.
  - mem_wr falls to 0 without waiting for a clock.
- Accept at cycle T (IDLE).
- Write: ACCESS at T+1, mem_wr high at T+1, rsp_valid at T+2. Throughput is one write per 3 cycles.
- Read: ACCESS at T+1, WAITLAT from T+2 to T+1+MEM_LAT, capture at the end of T+1+MEM_LAT, rsp_valid at T+2+MEM_LAT with rsp_rdata valid from the same cycle.
- With MEM_LAT=1, a read responds at T+3. Throughput is one read per 4 cycles.
- Next accept is possible at the IDLE cycle after DONE.
- Back-to-back requests from the same port are not merged.
- A request arriving while busy waits; ready is never asserted outside IDLE.
- Simultaneous requests in IDLE resolve in the same cycle. Exactly one ready is asserted.

## Test plan
- Single read: with MEM_LAT=1, memory word at 0x40 = 0xDEADBEEF_CAFEF00D, port 0 reads 0x40 accepted at T. Required: mem_addr=0x40 from T+1; rsp0_valid=1 only at T+3; rsp_rdata=0xDEADBEEF_CAFEF00D; rsp1_valid stays 0.
- Single write: port 1 writes 0x1234 to 0x80 accepted at T. Required: mem_wr=1 only at T+1 with mem_addr=0x80 and mem_wdata=0x1234; rsp1_valid at T+2; rsp_rdata unchanged. A subsequent port-0 read of 0x80 returns 0x1234.
- Tie: both ports request in the same IDLE cycle. Required: req0_ready=1 and req1_ready=0. Port 1 is accepted at the next IDLE cycle (T+4 for a read).
- Starvation: with MAX_WAIT=4, port 0 and port 1 both request continuously. Required: port 0 granted 4 times, then port 1 granted on the 5th arbitration, then starve_cnt=0 and port 0 wins again.
- Reset mid-read: assert Reset asynchronously during WAITLAT. Required: busy, mem_wr, rsp*_valid and rsp_rdata are 0 immediately. After release, the FSM is in IDLE and no rsp_valid is produced for the dropped read.
- Latency sweep: MEM_LAT=3, port 0 reads accepted at T. Required: rsp0_valid at T+5 with data captured during T+4. busy=1 from T+1 through T+5.
